// File: rtl/rotation_tracker.sv
// rotation_tracker
//
// Turns the once-per-revolution IR beam-break pulse into a live angular slice
// index. The revolution period is measured in clock cycles, split into
// ROTATIONAL_RES equal slices, and dtheta steps through them as the panel
// turns. frame_manager samples dtheta whenever theta_valid is high.
//
// Parameters
//   ROTATIONAL_RES  slices per revolution (power of two, >= 2)
//   PERIOD_WIDTH    width of the revolution period counter
//   MIN_PERIOD      shortest accepted revolution in cycles (>= ROTATIONAL_RES)
//
// Ports
//   clk_in       in   system clock
//   rst_in       in   asynchronous active-high reset
//   ir_tripped   in   raw IR sensor, asynchronous; rising edge marks angle 0
//   dtheta       out  current slice index
//   theta_valid  out  one-cycle pulse whenever dtheta is loaded or changes
//   locked       out  high while a valid period is held
//   period       out  last accepted revolution period, in cycles

module rotation_tracker #(
    parameter int ROTATIONAL_RES = 1024,
    parameter int PERIOD_WIDTH   = 24,
    parameter int MIN_PERIOD     = 4096
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              ir_tripped,
    output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    output logic                              theta_valid,
    output logic                              locked,
    output logic [PERIOD_WIDTH-1:0]           period
);

    localparam int RES_BITS = $clog2(ROTATIONAL_RES);
    localparam int SLICE_W  = PERIOD_WIDTH - RES_BITS;

    localparam logic [PERIOD_WIDTH-1:0] PCNT_MAX   = '1;
    localparam logic [PERIOD_WIDTH-1:0] MIN_P      = PERIOD_WIDTH'(MIN_PERIOD);
    // ROTATIONAL_RES is a power of two, so the last slice index is all-ones.
    localparam logic [RES_BITS-1:0]     DTHETA_MAX = '1;

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_ACQUIRE  = 2'd1,
        S_LOCKED   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_sync_meta;
    logic                    r_sync;
    logic                    r_ir_prev;

    logic [PERIOD_WIDTH-1:0] r_pcnt;
    logic [SLICE_W-1:0]      r_scnt;
    logic [SLICE_W-1:0]      r_slice_len;
    logic [RES_BITS-1:0]     r_dtheta;
    logic                    r_theta_valid;
    logic                    r_locked;
    logic [PERIOD_WIDTH-1:0] r_period;

    logic                    w_trip;
    logic                    w_active;
    logic                    w_timeout;
    logic                    w_accept;
    logic                    w_pcnt_clear;
    logic                    w_slice_end;

    // Rising edge of the synchronised sensor; one cycle wide by construction.
    assign w_trip    = r_sync & ~r_ir_prev;

    assign w_active  = (r_state == S_ACQUIRE) || (r_state == S_LOCKED);

    // A saturated counter is not a real measurement, so timeout outranks a
    // trip arriving in the same cycle.
    assign w_timeout = w_active && (r_pcnt == PCNT_MAX);

    // Trips closer than MIN_PERIOD are glitches and leave everything untouched.
    assign w_accept  = w_active && w_trip && !w_timeout && (r_pcnt >= MIN_P);

    assign w_pcnt_clear = ((r_state == S_UNLOCKED) && w_trip) || w_accept;

    // slice_len is at least 1 whenever LOCKED because MIN_PERIOD >= ROTATIONAL_RES.
    assign w_slice_end = (r_state == S_LOCKED) &&
                         (r_scnt == r_slice_len - SLICE_W'(1));

    // NOTE: clocked processes use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_UNLOCKED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default at the top of the block keeps every path assigned,
    // so no latch is inferred for the next-state value.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_UNLOCKED: begin
                if (w_trip) begin
                    w_state_next = S_ACQUIRE;
                end
            end
            S_ACQUIRE, S_LOCKED: begin
                if (w_timeout) begin
                    w_state_next = S_UNLOCKED;
                end else if (w_accept) begin
                    w_state_next = S_LOCKED;
                end
            end
            default: w_state_next = S_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sync_meta   <= 1'b0;
            r_sync        <= 1'b0;
            r_ir_prev     <= 1'b0;
            r_pcnt        <= '0;
            r_scnt        <= '0;
            r_slice_len   <= '0;
            r_dtheta      <= '0;
            r_theta_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_period      <= '0;
        end else begin
            r_sync_meta   <= ir_tripped;
            r_sync        <= r_sync_meta;
            r_ir_prev     <= r_sync;

            r_theta_valid <= 1'b0;
            // Registered copy of (state == LOCKED), aligned with r_state.
            r_locked      <= (w_state_next == S_LOCKED);

            if (w_pcnt_clear) begin
                r_pcnt <= PERIOD_WIDTH'(1);
            end else if (r_pcnt != PCNT_MAX) begin
                r_pcnt <= r_pcnt + PERIOD_WIDTH'(1);
            end

            if (w_timeout) begin
                // period keeps the last good measurement for diagnostics.
                r_dtheta <= '0;
                r_scnt   <= '0;
            end else if (w_accept) begin
                // Remainder cycles of the shift fall into the final slice.
                r_period      <= r_pcnt;
                r_slice_len   <= r_pcnt[PERIOD_WIDTH-1:RES_BITS];
                r_scnt        <= '0;
                r_dtheta      <= '0;
                r_theta_valid <= 1'b1;
            end else if (r_state == S_LOCKED) begin
                if (w_slice_end) begin
                    r_scnt <= '0;
                    // A slow panel parks on the last slice until the next trip.
                    if (r_dtheta != DTHETA_MAX) begin
                        r_dtheta      <= r_dtheta + RES_BITS'(1);
                        r_theta_valid <= 1'b1;
                    end
                end else begin
                    r_scnt <= r_scnt + SLICE_W'(1);
                end
            end
        end
    end

    assign dtheta      = r_dtheta;
    assign theta_valid = r_theta_valid;
    assign locked      = r_locked;
    assign period      = r_period;

endmodule

// File: doc/rotation_tracker.md
# rotation_tracker

Converts the once-per-revolution IR beam-break pulse into a live angular slice index for the spinning panel. It measures the revolution period in clock cycles, divides it into ROTATIONAL_RES equal slices, and advances `dtheta` as the panel turns. It sits directly upstream of `frame_manager`, which consumes `dtheta` and `theta_valid` to select which columns to load into the HUB75 driver.

## Interface
- ROTATIONAL_RES, 1024: slices per revolution; power of two ≥ 2.
- PERIOD_WIDTH, 24: width of the period counter; covers ≥ 1.39 s at 12 MHz.
- MIN_PERIOD, 4096: shortest revolution accepted, in cycles; shorter trip intervals are rejected as glitches. Must be ≥ ROTATIONAL_RES.
- clk_in  input  1  system clock (12 MHz).
- rst_in  input  1  reset, asynchronous, active-high.
- ir_tripped  input  1  raw IR sensor; asynchronous; a rising edge marks angle 0.
- dtheta  output  $clog2(ROTATIONAL_RES)  current slice index.
- theta_valid  output  1  one-cycle pulse whenever `dtheta` is loaded or changes.
- locked  output  1  high while a valid period is held.
- period  output  PERIOD_WIDTH  last accepted revolution period, in cycles.

## Operation
- **Input conditioning.** `ir_tripped` passes through a 2-flop synchronizer, then a rising-edge detector. The edge signal `trip` is one cycle wide.
- **Period counter `pcnt`** (PERIOD_WIDTH bits):
  - Set to 1 on an accepted trip.
  - Otherwise increments every cycle, saturating at all-ones.
  - The period measured at a trip is `pcnt` as it stands on that trip cycle.
- **States:** UNLOCKED, ACQUIRE, LOCKED. Reset enters UNLOCKED.
- **UNLOCKED:**
  - `trip` → ACQUIRE, `pcnt` <= 1.
  - `dtheta` holds 0; no `theta_valid`.
- **ACQUIRE or LOCKED, on `trip`:**
  - If `pcnt` < MIN_PERIOD, the trip is ignored entirely: no state, counter or output change.
  - Otherwise:
    - `period` <= `pcnt`.
    - `slice_len` <= `pcnt` >> log2(ROTATIONAL_RES).
    - `pcnt` <= 1, `scnt` <= 0, `dtheta` <= 0.
    - `theta_valid` <= 1; state → LOCKED.
- **LOCKED, no trip:**
  - `scnt` increments each cycle.
  - When `scnt` == `slice_len` − 1:
    - `scnt` <= 0.
    - If `dtheta` < ROTATIONAL_RES − 1: `dtheta` increments and `theta_valid` <= 1.
    - Otherwise `dtheta` holds at ROTATIONAL_RES − 1 (panel running slow). It never wraps without a trip.
- **Simultaneous trip and slice boundary:** the trip wins; `dtheta` goes to 0.
- **Timeout:** when `pcnt` reaches all-ones in ACQUIRE or LOCKED:
  - State → UNLOCKED.
  - `locked` <= 0, `dtheta` <= 0, `period` holds its last value.
  - No `theta_valid`.
- **Arithmetic:** remainder cycles from the shift are absorbed by the final slice. The `dtheta` clamp guarantees no overflow.

## Timing
- **Reset values:** `dtheta` = 0, `theta_valid` = 0, `locked` = 0, `period` = 0; `pcnt`, `scnt`, `slice_len` = 0; state UNLOCKED.
- **Reset mid-revolution:** all of the above apply immediately (asynchronous). A fresh acquisition then needs two accepted trips.
- **Trip latency:** a rising edge on `ir_tripped` that meets setup before clock edge k is seen as `trip` in the cycle after edge k+1. `dtheta` = 0, `theta_valid` = 1 and `locked` = 1 all become visible after edge k+2.
- **`locked`** equals (state == LOCKED), registered.
- **`theta_valid`** is registered and high for exactly one cycle per load or change. Its minimum spacing is MIN_PERIOD >> log2(ROTATIONAL_RES) cycles, which is ≥ 1.
- **No downstream backpressure:** `frame_manager` samples `dtheta` whenever `theta_valid` is high.

## Test plan
- **Reset then first trip:** assert `rst_in`, release, pulse `ir_tripped` once → state ACQUIRE, `locked` = 0, `dtheta` = 0, no `theta_valid`.
- **Lock and slice stepping:** trips 20480 cycles apart, RES = 1024 →
  - `period` = 20480, `locked` = 1, `dtheta` = 0 with a `theta_valid` pulse.
  - `dtheta` then increments every 20 cycles and reaches 1023 just before the next trip.
- **Slow revolution:** lock at 20480, next trip after 30000 cycles →
  - `dtheta` clamps at 1023 with no further `theta_valid`.
  - The trip sets `dtheta` = 0 and `period` = 30000.
- **Glitch rejection:** while locked at 20480, an extra trip 100 cycles after a valid one → ignored. `dtheta`, `period` and `scnt` are unaffected; the next trip at 20480 is still accepted.
- **Timeout:** lock, then stop trips for 2^24 − 1 cycles → `locked` = 0, `dtheta` = 0, state UNLOCKED. The next two trips 20480 apart re-lock.
- **Mid-operation reset:** assert `rst_in` while `dtheta` = 500 → all outputs return to reset values without waiting for a clock. Re-lock requires two trips.
